// File: rtl/video_ddr_frame_writer_if.sv
// Write-burst handshake between the frame writer (master) and the DDR write controller (slave).
interface video_ddr_frame_writer_if #(
  parameter int AXI_DATA_WIDTH = 128,
  parameter int AXI_ADDR_WIDTH = 28,
  parameter int LEN_WIDTH      = 10
);
  logic                      wr_burst_req;
  logic [LEN_WIDTH-1:0]      wr_burst_len;
  logic [AXI_ADDR_WIDTH-1:0] wr_burst_addr;
  logic                      wr_burst_data_req;
  logic [AXI_DATA_WIDTH-1:0] wr_burst_data;
  logic                      wr_burst_finish;

  modport master (
    output wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data,
    input  wr_burst_data_req, wr_burst_finish
  );

  modport slave (
    input  wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data,
    output wr_burst_data_req, wr_burst_finish
  );
endinterface

// File: rtl/video_ddr_frame_writer.sv
// Packs a 16-bit pixel stream into wide words, buffers them and writes frames into
// four rotating DDR buffers, publishing the base of the buffer being filled.
module video_ddr_frame_writer #(
  parameter int          AXI_DATA_WIDTH = 128,
  parameter int          AXI_ADDR_WIDTH = 28,
  parameter int          LEN_WIDTH      = 10,
  parameter int          IMG_COL        = 1280,
  parameter int          IMG_ROW        = 720,
  parameter int          BURST_LEN      = 16,
  parameter int          FIFO_DEPTH     = 64,
  parameter logic [27:0] BASE0          = 28'h0000000,
  parameter logic [27:0] BASE1          = 28'h0200000,
  parameter logic [27:0] BASE2          = 28'h0400000,
  parameter logic [27:0] BASE3          = 28'h0600000
) (
  input  logic                             axi_clk,
  input  logic                             rst_n,
  input  logic                             vin_vs,
  input  logic                             vin_de,
  input  logic [15:0]                      vin_data,
  video_ddr_frame_writer_if.master         wr,
  output logic [27:0]                      write_BaseDdr_addr,
  output logic                             frame_done,
  output logic                             overflow
);
  localparam int PPW         = AXI_DATA_WIDTH / 16;
  localparam int FRAME_WORDS = IMG_COL * IMG_ROW / PPW;
  localparam int FW_W        = $clog2(FRAME_WORDS + 1);
  localparam int PTR_W       = $clog2(FIFO_DEPTH);
  localparam int LVL_W       = PTR_W + 1;
  localparam int CNT_W       = (PPW > 1) ? $clog2(PPW) : 1;

  typedef enum logic [1:0] {IDLE, REQ, DATA, POST} state_t;

  state_t                    state_q, state_d;
  logic                      vs_q, vs_d;
  logic                      sof_pending_q, sof_pending_d;
  logic [CNT_W-1:0]          pix_cnt_q, pix_cnt_d;
  logic [AXI_DATA_WIDTH-1:0] pack_q, pack_d, word;
  logic [FW_W-1:0]           in_words_q, in_words_d;
  logic [FW_W-1:0]           wr_words_q, wr_words_d;
  logic                      frame_bad_q, frame_bad_d;
  logic                      overflow_q, overflow_d;
  logic                      frame_done_q, frame_done_d;
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]          level_q, level_d;
  logic [AXI_DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AXI_DATA_WIDTH-1:0] data_q, data_d;
  logic                      req_q, req_d;
  logic [LEN_WIDTH-1:0]      len_q, len_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]                idx_q, idx_d;
  logic [27:0]               base_q, base_d;
  logic                      sof_edge, push, wr_en, pop;

  function automatic logic [27:0] base_of(input logic [1:0] i);
    case (i)
      2'd0:    return BASE0;
      2'd1:    return BASE1;
      2'd2:    return BASE2;
      default: return BASE3;
    endcase
  endfunction

  always_comb begin
    state_d       = state_q;
    vs_d          = vin_vs;
    sof_pending_d = sof_pending_q;
    pix_cnt_d     = pix_cnt_q;
    pack_d        = pack_q;
    in_words_d    = in_words_q;
    wr_words_d    = wr_words_q;
    frame_bad_d   = frame_bad_q;
    overflow_d    = overflow_q;
    frame_done_d  = 1'b0;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    level_d       = level_q;
    data_d        = data_q;
    req_d         = req_q;
    len_d         = len_q;
    addr_d        = addr_q;
    idx_d         = idx_q;
    base_d        = base_q;
    word          = pack_q;
    push          = 1'b0;
    wr_en         = 1'b0;
    pop           = 1'b0;
    sof_edge      = vin_vs & ~vs_q;

    unique case (state_q)
      IDLE: begin
        if (level_q >= LVL_W'(BURST_LEN)) begin
          state_d = REQ;
          req_d   = 1'b1;
          len_d   = LEN_WIDTH'(BURST_LEN);
        end else if (level_q != '0 && (in_words_q == FW_W'(FRAME_WORDS) || sof_pending_q)) begin
          // Short flush also drains leftovers of a truncated frame, so a pending SOF can resolve.
          state_d = REQ;
          req_d   = 1'b1;
          len_d   = LEN_WIDTH'(level_q);
        end else if (sof_pending_q && level_q == '0) begin
          sof_pending_d = 1'b0;
          addr_d        = AXI_ADDR_WIDTH'(base_q);
          in_words_d    = '0;
          wr_words_d    = '0;
          frame_bad_d   = 1'b0;
        end
      end
      REQ: begin
        if (wr.wr_burst_data_req) state_d = DATA;
      end
      DATA: begin
        if (wr.wr_burst_finish) begin
          state_d = POST;
          req_d   = 1'b0;
        end
      end
      POST: begin
        addr_d     = addr_q + AXI_ADDR_WIDTH'(len_q) * AXI_ADDR_WIDTH'(PPW);
        wr_words_d = wr_words_q + FW_W'(len_q);
        if (wr_words_d == FW_W'(FRAME_WORDS) && !frame_bad_q) begin
          idx_d        = idx_q + 2'd1;
          base_d       = base_of(idx_q + 2'd1);
          frame_done_d = 1'b1;
        end
        state_d = IDLE;
      end
    endcase

    if (sof_edge) begin
      sof_pending_d = 1'b1;
      pix_cnt_d     = '0;
      pack_d        = '0;
    end else if (vin_de && !sof_pending_q && in_words_q != FW_W'(FRAME_WORDS)) begin
      word[16*int'(pix_cnt_q) +: 16] = vin_data;
      pack_d = word;
      if (pix_cnt_q == CNT_W'(PPW - 1)) begin
        pix_cnt_d  = '0;
        push       = 1'b1;
        in_words_d = in_words_q + FW_W'(1);
      end else begin
        pix_cnt_d = pix_cnt_q + CNT_W'(1);
      end
    end

    wr_en = push && (level_q != LVL_W'(FIFO_DEPTH));
    if (push && !wr_en) begin
      overflow_d  = 1'b1;
      frame_bad_d = 1'b1;
    end
    pop = (state_q == REQ || state_q == DATA) && wr.wr_burst_data_req && (level_q != '0);
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      data_d   = mem_q[rd_ptr_q];
    end
    level_d = level_q + LVL_W'(wr_en) - LVL_W'(pop);
  end

  always_ff @(posedge axi_clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= word;
  end

  always_ff @(posedge axi_clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      vs_q          <= 1'b0;
      sof_pending_q <= 1'b0;
      pix_cnt_q     <= '0;
      pack_q        <= '0;
      in_words_q    <= '0;
      wr_words_q    <= '0;
      frame_bad_q   <= 1'b0;
      overflow_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      data_q        <= '0;
      req_q         <= 1'b0;
      len_q         <= '0;
      addr_q        <= AXI_ADDR_WIDTH'(BASE0);
      idx_q         <= '0;
      base_q        <= BASE0;
    end else begin
      state_q       <= state_d;
      vs_q          <= vs_d;
      sof_pending_q <= sof_pending_d;
      pix_cnt_q     <= pix_cnt_d;
      pack_q        <= pack_d;
      in_words_q    <= in_words_d;
      wr_words_q    <= wr_words_d;
      frame_bad_q   <= frame_bad_d;
      overflow_q    <= overflow_d;
      frame_done_q  <= frame_done_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      data_q        <= data_d;
      req_q         <= req_d;
      len_q         <= len_d;
      addr_q        <= addr_d;
      idx_q         <= idx_d;
      base_q        <= base_d;
    end
  end

  assign wr.wr_burst_req    = req_q;
  assign wr.wr_burst_len    = len_q;
  assign wr.wr_burst_addr   = addr_q;
  assign wr.wr_burst_data   = data_q;
  assign write_BaseDdr_addr = base_q;
  assign frame_done         = frame_done_q;
  assign overflow           = overflow_q;
endmodule

// File: tb/tb_video_ddr_frame_writer.sv
// Bench for video_ddr_frame_writer: a reduced-size main instance driven by a frame table and
// a burst-controller model, plus a tiny-frame instance for the remainder flush.
module tb_video_ddr_frame_writer;
  localparam int DW = 128, AW = 28, LW = 10, PPW = 8;
  localparam int M_COL = 64, M_ROW = 16;
  localparam int F_COL = 24, F_ROW = 2;
  localparam logic [27:0] B0 = 28'h0000000, B1 = 28'h0200000, B2 = 28'h0400000, B3 = 28'h0600000;

  logic axi_clk = 1'b0;
  logic rst_n   = 1'b0;
  always #5 axi_clk = ~axi_clk;
  int cyc = 0;
  always @(posedge axi_clk) cyc <= cyc + 1;

  video_ddr_frame_writer_if #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .LEN_WIDTH(LW)) m_if ();
  video_ddr_frame_writer_if #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .LEN_WIDTH(LW)) f_if ();

  logic m_vs, m_de, m_done, m_ovf;
  logic [15:0] m_data;
  logic [27:0] m_base;
  logic f_vs, f_de, f_done, f_ovf;
  logic [15:0] f_data;
  logic [27:0] f_base;

  video_ddr_frame_writer #(
    .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .LEN_WIDTH(LW), .IMG_COL(M_COL), .IMG_ROW(M_ROW),
    .BURST_LEN(16), .FIFO_DEPTH(64), .BASE0(B0), .BASE1(B1), .BASE2(B2), .BASE3(B3)
  ) u_dut (
    .axi_clk(axi_clk), .rst_n(rst_n), .vin_vs(m_vs), .vin_de(m_de), .vin_data(m_data),
    .wr(m_if), .write_BaseDdr_addr(m_base), .frame_done(m_done), .overflow(m_ovf)
  );

  video_ddr_frame_writer #(
    .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .LEN_WIDTH(LW), .IMG_COL(F_COL), .IMG_ROW(F_ROW),
    .BURST_LEN(16), .FIFO_DEPTH(64), .BASE0(B0), .BASE1(B1), .BASE2(B2), .BASE3(B3)
  ) u_flush (
    .axi_clk(axi_clk), .rst_n(rst_n), .vin_vs(f_vs), .vin_de(f_de), .vin_data(f_data),
    .wr(f_if), .write_BaseDdr_addr(f_base), .frame_done(f_done), .overflow(f_ovf)
  );

  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge axi_clk);
    #1;
  endtask

  function automatic logic [15:0] pix(input int f, input int n);
    return 16'(f * 1024 + n);
  endfunction

  function automatic logic [127:0] exp_word(input int f, input int w);
    logic [127:0] r;
    for (int s = 0; s < PPW; s++) r[16*s +: 16] = pix(f, w * PPW + s);
    return r;
  endfunction

  // Controller model for the main instance: grants immediately unless hold_data is set.
  bit          ctrl_en = 0, busy = 0, hold_data = 0;
  int          cur_f = 0, burst_idx = 0, beat_no = 0, last_fin_cyc = 0;
  logic [27:0] exp_base = B0;

  initial begin : ctrl
    logic [27:0] a;
    int          len;
    m_if.wr_burst_data_req = 1'b0;
    m_if.wr_burst_finish   = 1'b0;
    wait (ctrl_en);
    forever begin
      @(negedge axi_clk);
      if (m_if.wr_burst_req) begin
        busy    = 1;
        beat_no = 0;
        a       = m_if.wr_burst_addr;
        len     = int'(m_if.wr_burst_len);
        check("burst_addr", a, exp_base + 28'(burst_idx * 128));
        check("burst_len", len, 16);
        if (len > 64) len = 64;
        while (hold_data) @(negedge axi_clk);
        tick();
        m_if.wr_burst_data_req = 1'b1;
        for (int b = 0; b < len; b++) begin
          beat_no = b;
          tick();
          if (b == len - 1) begin
            m_if.wr_burst_data_req = 1'b0;
            m_if.wr_burst_finish   = 1'b1;
            last_fin_cyc           = cyc;
          end
          @(negedge axi_clk);
          check("burst_data", m_if.wr_burst_data, exp_word(cur_f, int'((a - exp_base) >> 3) + b));
        end
        tick();
        m_if.wr_burst_finish = 1'b0;
        burst_idx++;
        busy = 0;
      end
    end
  end

  int fd_cnt = 0, fd_cyc = 0, f_fd_cnt = 0, f_bursts = 0;
  logic f_req_prev = 1'b0;
  always @(negedge axi_clk) begin
    if (rst_n && m_done) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
    if (rst_n && f_done) f_fd_cnt++;
    if (rst_n && f_if.wr_burst_req && !f_req_prev) f_bursts++;
    f_req_prev = f_if.wr_burst_req;
  end

  task automatic m_frame(input int f, input int npix, input logic [27:0] base);
    m_vs = 1'b1;
    repeat (3) tick();
    m_vs = 1'b0;
    cur_f     = f;
    exp_base  = base;
    burst_idx = 0;
    repeat (8) tick();
    for (int n = 0; n < npix; n++) begin
      m_de   = 1'b1;
      m_data = pix(f, n);
      tick();
    end
    m_de = 1'b0;
  endtask

  typedef struct {
    int          npix;
    bit          trunc;
    bit          hold;
    logic [27:0] start_base;
    int          exp_bursts;
    int          exp_done;
    logic [27:0] exp_base;
    bit          exp_ovf;
  } vec_t;

  vec_t tbl [8];

  initial begin : main
    int k;
    tbl[0] = '{npix: 256,  trunc: 1, hold: 0, start_base: B0, exp_bursts: 2, exp_done: 0, exp_base: B0, exp_ovf: 0};
    tbl[1] = '{npix: 1024, trunc: 0, hold: 0, start_base: B0, exp_bursts: 8, exp_done: 1, exp_base: B1, exp_ovf: 0};
    tbl[2] = '{npix: 1024, trunc: 0, hold: 0, start_base: B1, exp_bursts: 8, exp_done: 2, exp_base: B2, exp_ovf: 0};
    tbl[3] = '{npix: 1024, trunc: 0, hold: 0, start_base: B2, exp_bursts: 8, exp_done: 3, exp_base: B3, exp_ovf: 0};
    tbl[4] = '{npix: 1024, trunc: 0, hold: 0, start_base: B3, exp_bursts: 8, exp_done: 4, exp_base: B0, exp_ovf: 0};
    tbl[5] = '{npix: 1024, trunc: 0, hold: 0, start_base: B0, exp_bursts: 8, exp_done: 5, exp_base: B1, exp_ovf: 0};
    tbl[6] = '{npix: 1024, trunc: 0, hold: 1, start_base: B1, exp_bursts: 4, exp_done: 5, exp_base: B1, exp_ovf: 1};
    tbl[7] = '{npix: 1024, trunc: 0, hold: 0, start_base: B1, exp_bursts: 8, exp_done: 6, exp_base: B2, exp_ovf: 1};

    f_if.wr_burst_data_req = 1'b0;
    f_if.wr_burst_finish   = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      m_vs = 1'($urandom); m_de = 1'($urandom); m_data = 16'($urandom);
      f_vs = 1'($urandom); f_de = 1'($urandom); f_data = 16'($urandom);
      tick();
    end
    m_vs = 1'b0; m_de = 1'b0; m_data = '0;
    f_vs = 1'b0; f_de = 1'b0; f_data = '0;
    @(negedge axi_clk);
    check("rst_req", m_if.wr_burst_req, 1'b0);
    check("rst_len", m_if.wr_burst_len, '0);
    check("rst_addr", m_if.wr_burst_addr, B0);
    check("rst_data", m_if.wr_burst_data, '0);
    check("rst_base", m_base, B0);
    check("rst_ovf", m_ovf, 1'b0);
    check("rst_done", m_done, 1'b0);
    check("rst_flush_req", f_if.wr_burst_req, 1'b0);
    check("rst_flush_base", f_base, B0);
    tick();
    rst_n = 1'b1;
    tick();

    // Remainder flush: 48 pixels = 6 words, below one nominal burst.
    f_vs = 1'b1;
    repeat (3) tick();
    f_vs = 1'b0;
    repeat (8) tick();
    for (int n = 0; n < F_COL * F_ROW; n++) begin
      f_de = 1'b1;
      f_data = pix(20, n);
      tick();
    end
    f_de = 1'b0;
    k = 0;
    while (!f_if.wr_burst_req && k < 50) begin tick(); k++; end
    check("flush_req_seen", f_if.wr_burst_req, 1'b1);
    check("flush_len", f_if.wr_burst_len, 6);
    check("flush_addr", f_if.wr_burst_addr, B0);
    f_if.wr_burst_data_req = 1'b1;
    for (int b = 0; b < 6; b++) begin
      tick();
      if (b == 5) begin
        f_if.wr_burst_data_req = 1'b0;
        f_if.wr_burst_finish   = 1'b1;
      end
      check("flush_data", f_if.wr_burst_data, exp_word(20, b));
    end
    tick();
    f_if.wr_burst_finish = 1'b0;
    k = 0;
    while (f_fd_cnt == 0 && k < 20) begin tick(); k++; end
    repeat (20) tick();
    check("flush_frame_done", f_fd_cnt, 1);
    check("flush_bursts", f_bursts, 1);
    check("flush_base", f_base, B1);
    check("flush_ovf", f_ovf, 1'b0);

    ctrl_en = 1;
    for (int i = 0; i < 8; i++) begin
      int done_before;
      done_before = fd_cnt;
      hold_data = tbl[i].hold;
      m_frame(i + 1, tbl[i].npix, tbl[i].start_base);
      if (tbl[i].trunc) begin
        k = 0;
        while (!(busy && burst_idx == 1 && beat_no >= 2) && k < 300) begin tick(); k++; end
        check("trunc_in_data", m_if.wr_burst_req, 1'b1);
        m_vs = 1'b1;
        repeat (3) tick();
        m_vs = 1'b0;
      end
      if (tbl[i].hold) begin
        repeat (1000) tick();
        hold_data = 0;
      end
      k = 0;
      while (!(fd_cnt == tbl[i].exp_done && burst_idx == tbl[i].exp_bursts && !busy) && k < 800) begin
        tick();
        k++;
      end
      repeat (10) tick();
      check("frame_bursts", burst_idx, tbl[i].exp_bursts);
      check("frame_done_count", fd_cnt, tbl[i].exp_done);
      check("frame_base", m_base, tbl[i].exp_base);
      check("frame_overflow", m_ovf, tbl[i].exp_ovf);
      if (tbl[i].exp_done != done_before)
        check("frame_done_timing", fd_cyc - last_fin_cyc, 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
